// File: rtl/br_redirect_sched_if.sv
// Signal bundle between the pipeline branch-check logic, the redirect scheduler
// and the predictor update port.
interface br_redirect_sched_if #(
  parameter int CNT_W = 8
);
  logic             id_err;
  logic [31:0]      id_target;
  logic             exe_err;
  logic [31:0]      exe_target;
  logic             mem_err;
  logic [31:0]      mem_target;
  logic             res_valid;
  logic [31:0]      res_pc;
  logic [2:0]       res_type;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_if;
  logic             flush_id;
  logic             flush_exe;
  logic             upd_valid;
  logic             upd_ready;
  logic [31:0]      upd_pc;
  logic [2:0]       upd_type;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             q_full;
  logic [CNT_W-1:0] ovf_cnt;

  // Scheduler side
  modport master (
    input  id_err, id_target, exe_err, exe_target, mem_err, mem_target,
    input  res_valid, res_pc, res_type, res_taken, res_target, upd_ready,
    output redirect_valid, redirect_pc, flush_if, flush_id, flush_exe,
    output upd_valid, upd_pc, upd_type, upd_taken, upd_target, q_full, ovf_cnt
  );

  // Pipeline / predictor side
  modport slave (
    output id_err, id_target, exe_err, exe_target, mem_err, mem_target,
    output res_valid, res_pc, res_type, res_taken, res_target, upd_ready,
    input  redirect_valid, redirect_pc, flush_if, flush_id, flush_exe,
    input  upd_valid, upd_pc, upd_type, upd_taken, upd_target, q_full, ovf_cnt
  );
endinterface

// File: rtl/br_redirect_sched.sv
// Branch-mispredict redirect arbiter (oldest stage wins, one registered redirect)
// plus a resolved-branch FIFO feeding the predictor update port.
module br_redirect_sched #(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  br_redirect_sched_if.master bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int RW = 68;

  typedef enum logic {IDLE, REDIR} state_e;
  typedef enum logic [1:0] {SRC_ID, SRC_EXE, SRC_MEM} src_e;

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [31:0] pc_q, pc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= SRC_ID;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    src_d   = src_q;
    pc_d    = pc_q;
    if (state_q == IDLE) begin
      if (bus.mem_err) begin
        state_d = REDIR;
        src_d   = SRC_MEM;
        pc_d    = bus.mem_target;
      end else if (bus.exe_err) begin
        state_d = REDIR;
        src_d   = SRC_EXE;
        pc_d    = bus.exe_target;
      end else if (bus.id_err) begin
        state_d = REDIR;
        src_d   = SRC_ID;
        pc_d    = bus.id_target;
      end
    end else if (src_q == SRC_ID && bus.mem_err) begin
      // Only an older MEM error can override an ID redirect; everything else is wrong-path
      state_d = REDIR;
      src_d   = SRC_MEM;
      pc_d    = bus.mem_target;
    end

    bus.redirect_valid = (state_q == REDIR);
    bus.redirect_pc    = (state_q == REDIR) ? pc_q : 32'h0;
    bus.flush_if       = (state_q == REDIR);
    bus.flush_id       = (state_q == REDIR) && (src_q != SRC_ID);
    bus.flush_exe      = (state_q == REDIR) && (src_q == SRC_MEM);
  end

  // Update FIFO: pointers carry one wrap bit to tell full from empty
  logic [AW:0]      wr_q, rd_q;
  logic [RW-1:0]    mem_q [QDEPTH];
  logic [RW-1:0]    head;
  logic [CNT_W-1:0] ovf_q;
  logic             empty, full, push, pop, drop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign pop   = !empty && bus.upd_ready;
  assign push  = bus.res_valid && (!full || pop);
  assign drop  = bus.res_valid && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
      if (drop && ovf_q != '1) ovf_q <= ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {bus.res_pc, bus.res_type, bus.res_taken, bus.res_target};
  end

  // Storage is not cleared by reset, so the head is masked while empty
  assign head           = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign bus.upd_valid  = !empty;
  assign bus.upd_pc     = head[67:36];
  assign bus.upd_type   = head[35:33];
  assign bus.upd_taken  = head[32];
  assign bus.upd_target = head[31:0];
  assign bus.q_full     = full;
  assign bus.ovf_cnt    = ovf_q;
endmodule
